// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
//
// Time-multiplexed scan controller for a 4-digit seven-segment display.
// A programmable prescaler paces a 2-bit digit index (sel). For the selected
// digit, the block presents the nibble, the decimal point and a blank flag.
// The displayed value is double-buffered. A load lands in a shadow register
// and only reaches the display register on a frame boundary, so a frame never
// shows a mix of old and new digits.
//
// Parameters:
//   PRESCALE    clock cycles per digit step (1 .. 2^24-1)
//
// Ports:
//   clk         single clock, rising edge
//   reset       synchronous, active-high reset
//   en          scan enable; when low, the prescaler and sel hold
//   load        one-cycle strobe capturing data_in/dp_in into the shadow
//   data_in     four nibbles, [3:0] = digit 0 (rightmost)
//   dp_in       decimal point per digit, bit k = digit k
//   blank_lz    leading-zero blanking enable (registered before use)
//   sel         current digit index for the external 2-to-4 decoder
//   digit       nibble of the selected digit
//   dp          decimal point of the selected digit
//   blank       selected digit must be dark
//   tick        one-cycle pulse after every digit step
//   frame_done  one-cycle pulse after the 3 -> 0 step
//   pending     shadow holds data not yet committed to the display
// ---------------------------------------------------------------------------
module seg_scan_ctrl #(
    parameter int unsigned PRESCALE = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] data_in,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic [1:0]  sel,
    output logic [3:0]  digit,
    output logic        dp,
    output logic        blank,
    output logic        tick,
    output logic        frame_done,
    output logic        pending
);

    localparam logic [23:0] PCNT_MAX = 24'(PRESCALE - 1);

    logic [23:0] pcnt;
    logic [15:0] shadow_data;
    logic [3:0]  shadow_dp;
    logic [15:0] disp_data;
    logic [3:0]  disp_dp;
    logic        lz_q;
    logic        step;
    logic        boundary;
    logic [3:0]  lead_zero;

    // A step happens on the last enabled prescaler count. The step taken
    // while digit 3 is showing closes the frame, and only that step may
    // commit new display data.
    always_comb begin
        step     = en && (pcnt == PCNT_MAX);
        boundary = step && (sel == 2'd3);
    end

    // Scan timing: prescaler, digit index and the registered step pulses.
    // The blanking enable is also registered here. Because of that, no
    // input reaches an output without passing through a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt       <= 24'd0;
            sel        <= 2'd0;
            tick       <= 1'b0;
            frame_done <= 1'b0;
            lz_q       <= 1'b0;
        end else begin
            if (step) begin
                pcnt <= 24'd0;
                sel  <= sel + 2'd1;
            end else if (en) begin
                pcnt <= pcnt + 24'd1;
            end
            tick       <= step;
            frame_done <= boundary;
            lz_q       <= blank_lz;
        end
    end

    // Double buffer. The shadow always takes the latest load. On a frame
    // boundary, a load in that same cycle wins over older shadow contents
    // and goes straight to the display, so pending never rises for it.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_data <= 16'h0000;
            shadow_dp   <= 4'h0;
            disp_data   <= 16'h0000;
            disp_dp     <= 4'h0;
            pending     <= 1'b0;
        end else begin
            if (load) begin
                shadow_data <= data_in;
                shadow_dp   <= dp_in;
            end
            if (boundary && load) begin
                disp_data <= data_in;
                disp_dp   <= dp_in;
                pending   <= 1'b0;
            end else if (boundary && pending) begin
                disp_data <= shadow_data;
                disp_dp   <= shadow_dp;
                pending   <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    // Digit presentation from the display register, indexed by sel.
    // lead_zero[k] means nibbles k..3 are all zero. Digit 0 always shows,
    // so a display of 0000 still reads as "0".
    always_comb begin
        lead_zero    = 4'b0000;
        lead_zero[3] = (disp_data[15:12] == 4'h0);
        lead_zero[2] = (disp_data[15:8]  == 8'h00);
        lead_zero[1] = (disp_data[15:4]  == 12'h000);

        digit = 4'h0;
        case (sel)
            2'd0:    digit = disp_data[3:0];
            2'd1:    digit = disp_data[7:4];
            2'd2:    digit = disp_data[11:8];
            default: digit = disp_data[15:12];
        endcase

        dp    = disp_dp[sel];
        blank = lz_q && lead_zero[sel] && !disp_dp[sel];
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_ctrl
//
// Scoreboard bench for seg_scan_ctrl. Two instances share the same inputs:
// one with PRESCALE=4 and one with PRESCALE=1. For every driven cycle, the
// stimulus process pushes the expected outputs into a queue per instance.
// A separate monitor pops those entries and compares them with the outputs
// shortly after each falling edge.
//
// The reference model tracks the count of enabled cycles since reset. The
// scan position is derived from that count by division, and the display
// contents are picked out with shifts.
// ---------------------------------------------------------------------------
module tb_seg_scan_ctrl;

    localparam int P_A = 4;
    localparam int P_B = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [15:0] data_in = 16'h0000;
    logic [3:0]  dp_in = 4'h0;
    logic        blank_lz = 1'b0;

    logic [1:0]  sel_a, sel_b;
    logic [3:0]  digit_a, digit_b;
    logic        dp_a, dp_b, blank_a, blank_b, tick_a, tick_b;
    logic        frame_a, frame_b, pend_a, pend_b;

    seg_scan_ctrl #(.PRESCALE(P_A)) dut_a (
        .clk(clk), .reset(reset), .en(en), .load(load),
        .data_in(data_in), .dp_in(dp_in), .blank_lz(blank_lz),
        .sel(sel_a), .digit(digit_a), .dp(dp_a), .blank(blank_a),
        .tick(tick_a), .frame_done(frame_a), .pending(pend_a)
    );

    seg_scan_ctrl #(.PRESCALE(P_B)) dut_b (
        .clk(clk), .reset(reset), .en(en), .load(load),
        .data_in(data_in), .dp_in(dp_in), .blank_lz(blank_lz),
        .sel(sel_b), .digit(digit_b), .dp(dp_b), .blank(blank_b),
        .tick(tick_b), .frame_done(frame_b), .pending(pend_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          enCount;
        bit          tickQ;
        bit          frameQ;
        bit          pend;
        bit          lzQ;
        logic [15:0] sh;
        logic [3:0]  shDp;
        logic [15:0] ds;
        logic [3:0]  dsDp;
    } model_t;

    typedef struct {
        int sel;
        int digit;
        int dp;
        int blank;
        int tick;
        int frame;
        int pend;
    } exp_t;

    exp_t   qA[$];
    exp_t   qB[$];
    model_t mA;
    model_t mB;
    bit     mValid = 1'b0;
    bit     lzSet = 1'b0;
    int     checks = 0;
    int     errors = 0;

    // The scan position is simply how many whole prescale periods have gone by.
    function automatic int modelSel(model_t m, int p);
        return (m.enCount / p) % 4;
    endfunction

    // Expected outputs for the state the model is in right now.
    function automatic exp_t predict(model_t m, int p);
        exp_t        e;
        int          s;
        logic [15:0] upper;
        s       = modelSel(m, p);
        upper   = m.ds >> (4 * s);
        e.sel   = s;
        e.digit = int'(upper & 16'h000F);
        e.dp    = int'(m.dsDp[s]);
        e.blank = (m.lzQ && s != 0 && upper == 16'h0000 && !m.dsDp[s]) ? 1 : 0;
        e.tick  = int'(m.tickQ);
        e.frame = int'(m.frameQ);
        e.pend  = int'(m.pend);
        return e;
    endfunction

    // Model state after one clock edge with the given inputs applied.
    function automatic model_t advance(model_t m, int p, bit r, bit e, bit l,
                                       logic [15:0] d, logic [3:0] pd, bit lz);
        model_t n;
        bit     stepNow;
        bit     frameEnd;
        n = m;
        if (r) begin
            n.enCount = 0;
            n.tickQ   = 1'b0;
            n.frameQ  = 1'b0;
            n.pend    = 1'b0;
            n.lzQ     = 1'b0;
            n.sh      = 16'h0000;
            n.shDp    = 4'h0;
            n.ds      = 16'h0000;
            n.dsDp    = 4'h0;
            return n;
        end
        stepNow  = e && ((m.enCount % p) == p - 1);
        frameEnd = stepNow && (modelSel(m, p) == 3);
        n.tickQ  = stepNow;
        n.frameQ = frameEnd;
        n.lzQ    = lz;
        if (e) n.enCount = (m.enCount + 1) % (4 * p);
        if (l) begin
            n.sh   = d;
            n.shDp = pd;
        end
        if (frameEnd && l) begin
            n.ds   = d;
            n.dsDp = pd;
            n.pend = 1'b0;
        end else if (frameEnd && m.pend) begin
            n.ds   = m.sh;
            n.dsDp = m.shDp;
            n.pend = 1'b0;
        end else if (l) begin
            n.pend = 1'b1;
        end
        return n;
    endfunction

    // Drive one cycle of inputs, record what the outputs must show during
    // that cycle, then step both models across the next rising edge.
    task automatic applyStimulus(bit r, bit e, bit l, logic [15:0] d, logic [3:0] pd, bit lz);
        @(negedge clk);
        reset    = r;
        en       = e;
        load     = l;
        data_in  = d;
        dp_in    = pd;
        blank_lz = lz;
        if (mValid) begin
            qA.push_back(predict(mA, P_A));
            qB.push_back(predict(mB, P_B));
        end
        mA = advance(mA, P_A, r, e, l, d, pd, lz);
        mB = advance(mB, P_B, r, e, l, d, pd, lz);
        if (r) mValid = 1'b1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 4'h0, lzSet);
    endtask

    task automatic loadValue(logic [15:0] d, logic [3:0] pd);
        applyStimulus(1'b0, 1'b1, 1'b1, d, pd, lzSet);
    endtask

    // Run enabled cycles until the PRESCALE=4 model reaches the given digit.
    task automatic waitSel(int k);
        for (int i = 0; i < 64 && modelSel(mA, P_A) != k; i++) idle(1);
    endtask

    // Run enabled cycles until the PRESCALE=4 model is in its frame-end step.
    task automatic waitBoundary();
        for (int i = 0; i < 64 && mA.enCount != 4 * P_A - 1; i++) idle(1);
    endtask

    task automatic cmp(string name, logic [7:0] act, int expv);
        checks++;
        if (act !== 8'(expv)) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic checkOutput(string tag, exp_t e, logic [1:0] s, logic [3:0] d,
                               logic p, logic b, logic t, logic f, logic pe);
        cmp({tag, " sel"},        {6'd0, s},  e.sel);
        cmp({tag, " digit"},      {4'd0, d},  e.digit);
        cmp({tag, " dp"},         {7'd0, p},  e.dp);
        cmp({tag, " blank"},      {7'd0, b},  e.blank);
        cmp({tag, " tick"},       {7'd0, t},  e.tick);
        cmp({tag, " frame_done"}, {7'd0, f},  e.frame);
        cmp({tag, " pending"},    {7'd0, pe}, e.pend);
    endtask

    // Monitor: the outputs are registered, so they are stable one unit
    // after the falling edge. Consume whatever the stimulus side queued.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (qA.size() > 0) begin
                e = qA.pop_front();
                checkOutput("P4", e, sel_a, digit_a, dp_a, blank_a, tick_a, frame_a, pend_a);
            end
            if (qB.size() > 0) begin
                e = qB.pop_front();
                checkOutput("P1", e, sel_b, digit_b, dp_b, blank_b, tick_b, frame_b, pend_b);
            end
        end
    end

    // Stimulus: directed scenarios first, then a randomized run.
    initial begin
        logic [15:0] rd;
        logic [3:0]  rp;
        bit          rr, re, rl;

        $display("[TB] start");
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 4'h0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 16'hFFFF, 4'hF, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 4'h0, 1'b0);

        // Free-running scan across two frames.
        idle(34);

        // Load mid-frame; the display only changes after the 3 -> 0 step.
        waitSel(1);
        loadValue(16'h1234, 4'h0);
        idle(24);

        // Last load wins, then a load in the boundary cycle itself.
        waitSel(1);
        loadValue(16'hAAAA, 4'h1);
        idle(2);
        loadValue(16'h5555, 4'h2);
        idle(20);
        waitBoundary();
        loadValue(16'hBEEF, 4'h8);
        idle(18);

        // Leading-zero blanking.
        lzSet = 1'b1;
        loadValue(16'h0050, 4'h0);
        idle(34);
        loadValue(16'h0000, 4'b0100);
        idle(34);
        lzSet = 1'b0;
        idle(6);

        // Pause at digit 2, then resume.
        waitSel(2);
        idle(1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 4'h0, lzSet);
        idle(20);

        // Reset while a load is still pending.
        waitSel(1);
        loadValue(16'hCAFE, 4'hF);
        idle(2);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000, 4'h0, lzSet);
        idle(40);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            rr = ($urandom_range(0, 99) == 0);
            re = ($urandom_range(0, 9) != 0);
            rl = ($urandom_range(0, 7) == 0);
            rd = 16'($urandom);
            if ($urandom_range(0, 2) == 0) rd = rd & 16'h00FF;
            if ($urandom_range(0, 3) == 0) rd = rd & 16'h000F;
            rp = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 49) == 0) lzSet = ~lzSet;
            applyStimulus(rr, re, rl, rd, rp, lzSet);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 4'h0, lzSet);

        // Let the monitor drain its queues, with a bound on the wait.
        for (int i = 0; i < 8 && (qA.size() > 0 || qB.size() > 0); i++) @(negedge clk);
        #2;
        if (qA.size() > 0 || qB.size() > 0) begin
            errors++;
            checks++;
            $display("[TB] FAIL drain: got %0d entries left expected 0", qA.size() + qB.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for a 4-digit seven-segment display. It holds a 16-bit BCD/hex value in a double-buffered register and steps a 2-bit digit index at a programmable rate. It presents that index on `sel` to the downstream 2-to-4 decoder, which drives the one-hot digit enables. It also presents the nibble, decimal point and blank flag for the selected digit to the segment encoder.

## Interface
Parameters:
- `PRESCALE`, default 50000: clock cycles per digit step; legal range 1 to 2^24-1.

Ports:
- `clk`, input, 1: the block's single clock. All state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `en`, input, 1: scan enable. When low, the prescaler and `sel` hold.
- `load`, input, 1: single-cycle strobe that captures `data_in` and `dp_in` into the shadow register.
- `data_in`, input, 16: four nibbles; `[3:0]` is digit 0 (rightmost), `[15:12]` is digit 3.
- `dp_in`, input, 4: decimal point per digit; bit k belongs to digit k.
- `blank_lz`, input, 1: leading-zero blanking enable.
- `sel`, output, 2: current digit index, fed to the decoder input `w`.
- `digit`, output, 4: nibble of the selected digit from the display register.
- `dp`, output, 1: decimal point of the selected digit.
- `blank`, output, 1: high means the selected digit must be dark.
- `tick`, output, 1: one-cycle pulse on every digit step.
- `frame_done`, output, 1: one-cycle pulse on the step from digit 3 to digit 0.
- `pending`, output, 1: the shadow register holds data not yet committed to the display register.

## Operation
State:
- Prescaler `pcnt`, 24 bits.
- Scan index `sel`.
- Shadow register: 16 bits data plus 4 bits dp.
- Display register: 16 bits data plus 4 bits dp.
- `pending` flag.

Prescaler and scan index:
- With `en`=1, `pcnt` counts from 0 to PRESCALE-1.
- When `pcnt`==PRESCALE-1 and `en`=1 (a step cycle): `pcnt` wraps to 0 and `sel` increments modulo 4 (3 wraps to 0).
- With `en`=0, `pcnt` and `sel` hold and no step occurs.

Shadow and display registers:
- `load`=1: the shadow register takes `{data_in, dp_in}` and `pending` is set.
- A load while `pending`=1 overwrites the shadow register; the last load wins.
- Commit happens only on a frame boundary, i.e. a step cycle with `sel`==3. This prevents mid-frame tearing.
  - If `pending`=1, the display register takes the shadow contents and `pending` clears.
  - If `load` is high in the same boundary cycle, `data_in` and `dp_in` commit directly to the display register, the shadow register is also written, and `pending` ends at 0.
  - With `pending`=0 and no load, the display register holds.

Outputs:
- `digit` and `dp` are combinational selects from the display register indexed by the `sel` register. There is no combinational path from any input to any output.
- `blank`:
  - With `blank_lz`=0, `blank` is 0.
  - With `blank_lz`=1, digit k (k = 1, 2, 3) is blanked when display nibbles k through 3 are all zero and dp bit k is 0.
  - Digit 0 is never blanked.
- `tick` and `frame_done` are registered. Each is high for the one cycle after its step cycle.

Reset:
- Forces `pcnt`=0, `sel`=0, shadow register = 0, display register = 0, `pending`=0, `tick`=0, `frame_done`=0.
- Resulting outputs: `digit`=0, `dp`=0, `blank`=0.
- Reset has priority over `load` and `en`.
- A reset mid-frame discards any pending shadow data.

## Timing
- `sel` changes on the clock edge that ends a step cycle. `digit`, `dp` and `blank` follow in the same cycle, with zero latency relative to `sel`.
- After reset release with `en`=1, the first step cycle is cycle PRESCALE counting from 1. `sel` becomes 1 in the next cycle. Steps then repeat every PRESCALE cycles.
- Load-to-display latency runs from the `load` cycle to the next step cycle with `sel`==3. The maximum is 4×PRESCALE cycles.
- `pending` goes high in the cycle after `load` and low in the cycle after the commit.
- PRESCALE=1: every enabled cycle is a step cycle, and `tick` stays high continuously while `en`=1.

## Test plan
- PRESCALE=4, reset, then `en`=1 held → `sel` sequence is 0,0,0,0,1,1,1,1,2,… and `tick` pulses every 4 cycles. `frame_done` pulses once per 16 cycles, after the 3→0 step.
- `load` with `data_in`=16'h1234 while `sel`=1 → `pending`=1 and `digit` keeps its old value through digits 1, 2 and 3. After the 3→0 step: `digit`=4 at sel 0, 3 at sel 1, 2 at sel 2, 1 at sel 3, and `pending`=0.
- Two loads before a boundary (16'hAAAA, then 16'h5555) → only 5555 is displayed. `load` 16'hBEEF in the boundary cycle itself → BEEF is shown from the next cycle and `pending` never asserts.
- `blank_lz`=1 with display 16'h0050:
  - `blank`=1 at sel 3 and sel 2.
  - `blank`=0 at sel 1 (`digit`=5) and at sel 0 (`digit`=0).
  - With 16'h0000 and `dp_in`=4'b0100: `blank`=1 at sel 3 and sel 1, `blank`=0 at sel 2 and sel 0.
- Drop `en` at `sel`=2 for 10 cycles → `sel`, `pcnt`, `tick` and `frame_done` are frozen. On resume, the remaining count of the current digit completes.
- Assert `reset` mid-frame with `pending`=1 → the next cycle shows `sel`=0, `pending`=0, `digit`=0, `dp`=0, and the previously loaded data is never displayed.
